// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer: FSM state encoding and counter sizing.
package debounce_pkg;

    localparam logic DB_IDLE = 1'b0;
    localparam logic DB_PEND = 1'b1;

    typedef enum logic {
        S_IDLE = DB_IDLE,
        S_PEND = DB_PEND
    } db_state_e;

    // The counter must hold values up to STABLE_CYCLES.
    function automatic int db_cnt_width(input int stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: qualification FSM, sample counter, level register and
// optional rise/fall strobes (built only when DEBOUNCE_EDGE_EN is defined).
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 16,
    parameter logic INIT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic dbg_pend
);

    localparam int CW = db_cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    db_state_e     state;
    logic [CW-1:0] cnt;

    assign dbg_pend = (state == S_PEND);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            level <= INIT;
        end else if (tick) begin
            unique case (state)
                S_IDLE: begin
                    if (in != level) begin
                        if (STABLE_CYCLES == 1) begin
                            level <= in;
                        end else begin
                            state <= S_PEND;
                            cnt   <= CW'(1);
                        end
                    end
                end
                S_PEND: begin
                    // A sample matching the current level discards the glitch.
                    if (in == level) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        level <= in;
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef DEBOUNCE_EDGE_EN
    logic accept;

    // Mirrors the conditions under which the FSM above takes the new value.
    always_comb begin
        accept = 1'b0;
        if (tick && (in != level)) begin
            if (STABLE_CYCLES == 1)
                accept = 1'b1;
            else
                accept = (state == S_PEND) && (cnt == LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= accept & in;
            fall <= accept & ~in;
        end
    end
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel debouncer: WIDTH independent debounce_channel instances.
// Edge strobes are generated only when DEBOUNCE_EDGE_EN is defined.
module input_debouncer #(
    parameter int               WIDTH         = 1,
    parameter int               STABLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [WIDTH-1:0] dbg_pend
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .INIT         (INIT[i])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .in      (in[i]),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i]),
            .dbg_pend(dbg_pend[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: WIDTH=2, STABLE_CYCLES=4, INIT=0.
// Expected strobes follow DEBOUNCE_EDGE_EN (zero when it is undefined).
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [1:0] in_r;
    logic [1:0] level, rise, fall, dbg_pend;

    int n_cmp = 0;
    int n_err = 0;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    input_debouncer #(
        .WIDTH        (2),
        .STABLE_CYCLES(4),
        .INIT         (2'b00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .in      (in_r),
        .level   (level),
        .rise    (rise),
        .fall    (fall),
        .dbg_pend(dbg_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] strobe(input logic [1:0] v);
        return EDGE ? v : 2'b00;
    endfunction

    // Apply inputs, then let one rising edge pass and settle.
    task automatic cyc(input logic [1:0] v, input logic t);
        in_r = v;
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [1:0] lv,
                              input logic [1:0] rs, input logic [1:0] fl);
        check({tag, ".level"}, 32'(level), 32'(lv));
        check({tag, ".rise"},  32'(rise),  32'(strobe(rs)));
        check({tag, ".fall"},  32'(fall),  32'(strobe(fl)));
    endtask

    // Return channel 0 from 1 to 0 with a full qualification.
    task automatic drop_ch0(input string tag);
        for (int i = 1; i <= 4; i++) begin
            cyc(2'b00, 1'b1);
            expect_out(tag, (i == 4) ? 2'b00 : 2'b01, 2'b00, (i == 4) ? 2'b01 : 2'b00);
        end
        cyc(2'b00, 1'b1);
        expect_out({tag, "_after"}, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        int nrise;
        logic [8:0] pat;

        // Reset held for two cycles, then quiet input.
        rst = 1'b1; tick = 1'b1; in_r = 2'b00;
        @(posedge clk); @(posedge clk); #1;
        expect_out("reset", 2'b00, 2'b00, 2'b00);
        check("reset.pend", 32'(dbg_pend), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(2'b00, 1'b1);
            expect_out("quiet", 2'b00, 2'b00, 2'b00);
        end

        // Clean rise: level and strobe after the 4th sample, strobe gone next cycle.
        for (int i = 1; i <= 4; i++) begin
            cyc(2'b01, 1'b1);
            if (i == 1) check("rise.pend", 32'(dbg_pend), 32'd1);
            expect_out("clean_rise", (i == 4) ? 2'b01 : 2'b00, (i == 4) ? 2'b01 : 2'b00, 2'b00);
        end
        cyc(2'b01, 1'b1);
        expect_out("clean_rise_after", 2'b01, 2'b00, 2'b00);
        drop_ch0("clean_fall");

        // Glitch of three samples is discarded.
        for (int i = 1; i <= 3; i++) begin
            cyc(2'b01, 1'b1);
            expect_out("glitch", 2'b00, 2'b00, 2'b00);
        end
        cyc(2'b00, 1'b1);
        expect_out("glitch_end", 2'b00, 2'b00, 2'b00);
        check("glitch.pend", 32'(dbg_pend), 32'd0);

        // Four samples then give exactly one rise.
        nrise = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc(2'b01, 1'b1);
            if (rise[0]) nrise++;
        end
        check("glitch.rise_count", 32'(nrise), EDGE ? 32'd1 : 32'd0);
        check("glitch.level", 32'(level), 32'd1);
        drop_ch0("glitch_fall");

        // Sparse tick: every third cycle; only ticks count toward qualification.
        for (int t = 1; t <= 4; t++) begin
            cyc(2'b01, 1'b1);
            expect_out("sparse_tick", (t == 4) ? 2'b01 : 2'b00, (t == 4) ? 2'b01 : 2'b00, 2'b00);
            for (int j = 0; j < 2; j++) begin
                cyc(2'b01, 1'b0);
                expect_out("sparse_idle", (t == 4) ? 2'b01 : 2'b00, 2'b00, 2'b00);
                check("sparse.pend", 32'(dbg_pend), (t == 4) ? 32'd0 : 32'd1);
            end
        end
        drop_ch0("sparse_fall");

        // Reset mid-count discards two qualified samples.
        cyc(2'b01, 1'b1);
        cyc(2'b01, 1'b1);
        check("midrst.pend_before", 32'(dbg_pend), 32'd1);
        rst = 1'b1;
        cyc(2'b01, 1'b1);
        rst = 1'b0;
        expect_out("midrst", 2'b00, 2'b00, 2'b00);
        check("midrst.pend", 32'(dbg_pend), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(2'b01, 1'b1);
            expect_out("midrst_requal", (i == 4) ? 2'b01 : 2'b00, (i == 4) ? 2'b01 : 2'b00, 2'b00);
        end
        drop_ch0("midrst_fall");

        // Channel 0 bounces (never 4 ones in a row) while channel 1 holds 1.
        pat = 9'b011101101;
        for (int i = 0; i < 9; i++) begin
            cyc({1'b1, pat[i]}, 1'b1);
            expect_out("multi", (i >= 3) ? 2'b10 : 2'b00, (i == 3) ? 2'b10 : 2'b00, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/input_debouncer.md
# input_debouncer

Multi-channel debouncer and edge detector that consumes the output of the multi-flop clock-domain synchronizer in the same clock domain. It filters bounce and glitches from externally sourced signals such as buttons, switches and slow status lines. Each channel produces a clean level plus single-cycle rise and fall strobes for downstream control logic. The block has a single clock and no internal synchronizer; inputs must already be synchronous to `clk`.

## Interface
- `WIDTH`, default 1: number of independent channels.
- `STABLE_CYCLES`, default 16: consecutive qualifying samples of a new value needed before `level` accepts it. Must be ≥ 1.
- `INIT`, default {WIDTH{1'b0}}: reset value of `level`.
- `clk`  in  1  clock, rising edge. Same clock as the upstream synchronizer.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  sample enable. Evaluation happens only on cycles where `tick` is 1. Tie it to 1 to sample every cycle.
- `in`  in  WIDTH  synchronized raw inputs.
- `level`  out  WIDTH  debounced level.
- `rise`  out  WIDTH  one-cycle strobe when `level` goes 0→1.
- `fall`  out  WIDTH  one-cycle strobe when `level` goes 1→0.

## Operation
- Each channel is independent. It holds a sample counter `cnt` of width $clog2(STABLE_CYCLES+1) and a two-state FSM.
- FSM states:
  - IDLE: `in[i] == level[i]`, `cnt` = 0.
  - PEND: a differing value is being qualified.
- On a `tick` cycle:
  - IDLE, `in[i] != level[i]`:
    - If STABLE_CYCLES == 1, accept immediately.
    - Otherwise go to PEND with `cnt` = 1.
  - PEND, `in[i] == level[i]`: return to IDLE with `cnt` = 0. The glitch is discarded.
  - PEND, `in[i] != level[i]`, `cnt` == STABLE_CYCLES−1: accept.
  - PEND, otherwise: `cnt` + 1.
- Accept means, registered on the same edge: `level[i]` <= `in[i]`; `cnt` <= 0; state <= IDLE; `rise[i]` or `fall[i]` <= 1 according to the new value.
- On a non-`tick` cycle, FSM and `cnt` hold, and `rise`/`fall` are 0.
- `rise[i]` and `fall[i]` are never both 1. Each is high for exactly one cycle per accepted transition.
- Counter saturation cannot occur, because accept resets `cnt`.

## Timing
- Reset values: `level` = INIT; `rise` = 0; `fall` = 0; all `cnt` = 0; all FSMs in IDLE.
- `rst` takes priority over `tick` and `in`. Reset mid-PEND discards partial qualification. After reset, a new value needs a full STABLE_CYCLES samples.
- If `in` differs from INIT after reset, the value is qualified normally and produces one edge strobe.
- Latency with `tick` = 1: `in` changes and is sampled at edge k and is held. `level`, together with the strobe, updates at edge k+STABLE_CYCLES−1.
- With `tick` = 1, `level` is visible STABLE_CYCLES−1 cycles after the first differing sample, i.e. STABLE_CYCLES register delays counting the sampling edge.
- With sparse `tick`, latency counts `tick` cycles only.
- All outputs are registered. There is no combinational path from `in` to any output.

## Configuration
- `DEBOUNCE_EDGE_EN` defined: `rise` and `fall` are generated as specified.
- `DEBOUNCE_EDGE_EN` undefined:
  - `rise` and `fall` ports remain but are tied to 0.
  - Edge registers are not built.
  - `level` behaviour is unchanged.

## Structure
- Shared package `debounce_pkg` holds:
  - the FSM state encoding localparams `DB_IDLE` and `DB_PEND`;
  - a counter-width helper function.
- Sub-module `debounce_channel` implements one channel: FSM, counter, level and edge registers.
- `input_debouncer` instantiates `debounce_channel` WIDTH times in a generate loop and contains no other logic.

## Test plan
All scenarios use STABLE_CYCLES = 4, INIT = 0 and `tick` = 1 unless stated otherwise.
- **Reset:** `rst` = 1 for 2 cycles with `in` = 0, then `in` held 0 for 20 cycles. Required: `level` = 0 throughout, and no `rise` or `fall` ever.
- **Clean rise:** `in` 0→1 sampled at edge k and held. Required: `level` = 1 and `rise` = 1 after edge k+3; `rise` returns to 0 after edge k+4; `fall` stays 0.
- **Glitch:**
  - `in` = 1 for 3 cycles, then 0. Required: `level` stays 0 with no strobes.
  - Then `in` = 1 for 4 cycles. Required: exactly one `rise`.
- **Sparse tick:** `tick` high every 3rd cycle; `in` 0→1 held. Required: `level` flips on the 4th `tick` after the change, never earlier; `cnt` holds between ticks.
- **Reset mid-count:** `in` = 1 for 2 ticks, then a 1-cycle `rst` pulse with `in` still 1. Required: `level` = 0 after the reset; `rise` occurs only after 4 further samples.
- **Multi-channel and macro:** WIDTH = 2; `in[0]` bounces while `in[1]` is stable 1. Required: channels are independent and only `rise[1]` fires. Rebuild without `DEBOUNCE_EDGE_EN`: `level` waveform is identical, and `rise` = `fall` = 0 always.
